instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a pc register drives a combinational instruction
// memory, and fetched {pc, instr} pairs are buffered in a small FIFO that the
// decode stage drains with a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at the new target.
// Optional feature: define IFU_HALT_ON_ZERO_EN to make an all-zero
// instruction word stop fetching until the next redirect or reset.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted_q, halted_d;

    logic [31:0]   fq_pc_q    [FQ_DEPTH];
    logic [31:0]   fq_instr_q [FQ_DEPTH];

    logic          deq_c;
    logic          fetch_c;

    // Memory address and head-of-queue view, all derived from registers.
    assign imem_addr = {2'b00, pc_q[31:2]};
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? fq_pc_q[head_q]    : 32'h0;
    assign out_instr = out_valid ? fq_instr_q[head_q] : 32'h0;
    assign halted    = halted_q;

    // Handshake and fetch-enable decode; a full queue may still fetch when
    // the head leaves on the same edge.
    assign deq_c   = out_valid & out_ready;
    assign fetch_c = ~halted_q & ~redirect_valid &
                     ((count_q < CW'(FQ_DEPTH)) | deq_c);

    // Next-state for pc, pointers, occupancy and halt flag.
    always_comb begin
        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        halted_d = halted_q;

        if (redirect_valid) begin
            // Redirect wins: every queued entry is dropped.
            pc_d     = {redirect_pc[31:2], 2'b00};
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (deq_c) begin
                head_d = head_q + PW'(1);
            end
            if (fetch_c) begin
                tail_d = tail_q + PW'(1);
                pc_d   = pc_q + 32'd4;
`ifdef IFU_HALT_ON_ZERO_EN
                if (imem_data == 32'h0) begin
                    halted_d = 1'b1;
                end
`endif
            end
            case ({fetch_c, deq_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Queue storage; contents are only observed through out_valid gating.
    always_ff @(posedge clk) begin
        if (fetch_c) begin
            fq_pc_q[tail_q]    <= pc_q;
            fq_instr_q[tail_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program-order reference stream is kept in a queue
// and every consumer handshake is checked against it, alongside directed
// checks of reset, latency, back-pressure, redirect, wrap and async reset.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    instr_fetch #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory contents by word address.
    function automatic logic [31:0] word_at(input logic [31:0] waddr);
        case (waddr)
            32'd0:   return 32'h0000_0000;
            32'd1:   return 32'h0010_0113;
            32'd2:   return 32'h0010_0193;
            32'd3:   return 32'h0021_8133;
            32'd4:   return 32'h0021_81b3;
            32'd5:   return 32'hffff_f26f;
            default: return waddr * 32'h9E37_79B9 + 32'h0135_7BDF;
        endcase
    endfunction

    assign imem_data = word_at(imem_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction stream in program order from the
    // latest reset/redirect target.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    bit          m_stop;

    task automatic model_refill();
        exp_t e;
        while (exp_q.size() < 4 && !m_stop) begin
            e.pc    = m_pc;
            e.instr = word_at(m_pc >> 2);
            exp_q.push_back(e);
`ifdef IFU_HALT_ON_ZERO_EN
            if (e.instr == 32'h0) m_stop = 1'b1;
`endif
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] target);
        exp_q.delete();
        m_pc   = {target[31:2], 2'b00};
        m_stop = 1'b0;
        model_refill();
    endtask

    // Monitor: compares every accepted head against the reference stream.
    bit          prev_stall = 1'b0;
    logic [31:0] last_pc, last_instr;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            model_restart(RST_PC);
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_pc", out_pc, last_pc);
                check("hold_instr", out_instr, last_instr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got pc %h, expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", out_pc, e.pc);
                    check("sb_instr", out_instr, e.instr);
                end
            end
`ifndef IFU_HALT_ON_ZERO_EN
            check("halted_tied", 32'(halted), 32'd0);
`endif
            prev_stall = out_valid && !out_ready && !redirect_valid;
            last_pc    = out_pc;
            last_instr = out_instr;
            if (redirect_valid) model_restart(redirect_pc);
            else                model_refill();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", imem_addr, {2'b00, RST_PC[31:2]});
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);

`ifdef IFU_HALT_ON_ZERO_EN
        out_ready = 1'b1;
        #11 rst_n = 1'b1;
        tick();
        check("halt_valid", 32'(out_valid), 32'd1);
        check("halt_pc", out_pc, 32'h0);
        check("halt_instr", out_instr, 32'h0);
        check("halt_flag", 32'(halted), 32'd1);
        tick();
        tick();
        check("halt_empty", 32'(out_valid), 32'd0);
        check("halt_addr", imem_addr, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        tick();
        redirect_valid = 1'b0;
        check("unhalt_flag", 32'(halted), 32'd0);
        tick();
        check("unhalt_pc", out_pc, 32'h4);
        check("unhalt_instr", out_instr, 32'h0010_0113);
`else
        #11 rst_n = 1'b1;
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_addr", imem_addr, 32'd1);
        tick();
        tick();
        check("full_addr", imem_addr, 32'd2);
        check("full_pc", out_pc, 32'h0);
        check("full_instr", out_instr, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", out_pc, 32'(4 * (k + 1)));
            check("stream_instr", out_instr, word_at(32'(k + 1)));
        end
`endif

        // Redirect into a full queue while the head is being consumed.
        out_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0013;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", 32'(out_valid), 32'd0);
        check("redir_addr", imem_addr, 32'd4);
        tick();
        check("redir_valid", 32'(out_valid), 32'd1);
        check("redir_pc", out_pc, 32'h10);

        // pc wrap across the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        tick();
        check("wrap_pc2", out_pc, 32'h0);

        // Asynchronous reset with entries queued.
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr", imem_addr, {2'b00, RST_PC[31:2]});
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("arst_restart_valid", 32'(out_valid), 32'd1);
        check("arst_restart_pc", out_pc, RST_PC);

        // Randomized traffic checked by the monitor.
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc = 32'($urandom_range(0, 63));
            endcase
            tick();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
